// File: rtl/ar4_pkg.sv
// Shared types and constants for the AR4 coefficient/operand sequencer.
package ar4_pkg;

   localparam int NUM_A_DEFAULT   = 4;
   localparam int TIMEOUT_DEFAULT = 255;
   localparam int DATA_W          = 8;
   localparam int RESULT_W        = 32;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button followed by a rising-edge detector.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= btn;
         sync <= meta;
         prev <= sync;
      end
   end

   assign press = sync & ~prev;

endmodule

// File: rtl/ar4_sequencer.sv
// Button-driven sequencer: loads A coefficients and X, launches the AR4
// datapath, waits for its result with a timeout and holds the captured value.
module ar4_sequencer
   import ar4_pkg::*;
#(
   parameter int NUM_A   = NUM_A_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          swData,
   input  logic                       GetA,
   input  logic                       GetX,
   input  logic                       startAR4,
   input  logic                       dpReady,
   input  logic signed [RESULT_W-1:0] dpResult,
   output logic [DATA_W-1:0]          aData,
   output logic [1:0]                 aIdx,
   output logic                       aWe,
   output logic [DATA_W-1:0]          xData,
   output logic                       dpStart,
   output logic signed [RESULT_W-1:0] outAR4,
   output logic                       readyAR4,
   output logic                       busy,
   output logic                       err
);

   localparam int CNT_W = $clog2(NUM_A + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic press_a;
   logic press_x;
   logic press_start;

   state_t state;
   state_t state_next;

   logic [1:0]       idx;
   logic [CNT_W-1:0] a_count;
   logic             x_valid;
   logic [TMO_W-1:0] wait_cnt;
   logic             capture_q;

   logic do_write;
   logic do_x;
   logic do_start;
   logic do_capture;
   logic do_timeout;

   btn_sync_edge u_sync_a     (.clk(clk), .rst(rst), .btn(GetA),     .press(press_a));
   btn_sync_edge u_sync_x     (.clk(clk), .rst(rst), .btn(GetX),     .press(press_x));
   btn_sync_edge u_sync_start (.clk(clk), .rst(rst), .btn(startAR4), .press(press_start));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A start press always shadows A/X presses in the same cycle, even when it is refused.
   always_comb begin
      state_next = state;
      do_write   = 1'b0;
      do_x       = 1'b0;
      do_start   = 1'b0;
      do_capture = 1'b0;
      do_timeout = 1'b0;
      case (state)
         IDLE, DONE, ERR: begin
            if (press_start) begin
               if (a_count == CNT_W'(NUM_A) && x_valid) begin
                  do_start   = 1'b1;
                  state_next = START;
               end
            end else if (press_a) begin
               do_write   = 1'b1;
               state_next = IDLE;
            end else if (press_x) begin
               do_x       = 1'b1;
               state_next = IDLE;
            end
         end
         START: state_next = WAIT;
         WAIT: begin
            if (dpReady) begin
               do_capture = 1'b1;
               state_next = DONE;
            end else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
               do_timeout = 1'b1;
               state_next = ERR;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign dpStart = (state == START);
   assign busy    = (state == START) || (state == WAIT);

   // readyAR4 rises one cycle after the capture; leaving DONE in that cycle wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx       <= '0;
         a_count   <= '0;
         x_valid   <= 1'b0;
         xData     <= '0;
         aData     <= '0;
         aIdx      <= '0;
         aWe       <= 1'b0;
         outAR4    <= '0;
         readyAR4  <= 1'b0;
         err       <= 1'b0;
         wait_cnt  <= '0;
         capture_q <= 1'b0;
      end else begin
         aWe       <= do_write;
         capture_q <= do_capture;
         if (do_write) begin
            aData <= swData;
            aIdx  <= idx;
            idx   <= (idx == 2'(NUM_A - 1)) ? 2'd0 : idx + 2'd1;
            if (a_count != CNT_W'(NUM_A)) begin
               a_count <= a_count + CNT_W'(1);
            end
         end
         if (do_x) begin
            xData   <= swData;
            x_valid <= 1'b1;
         end
         if (state == START) begin
            wait_cnt <= '0;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + TMO_W'(1);
         end
         if (do_capture) begin
            outAR4 <= dpResult;
         end
         if (do_start || do_write || do_x) begin
            readyAR4 <= 1'b0;
         end else if (capture_q) begin
            readyAR4 <= 1'b1;
         end
         if (do_timeout) begin
            err <= 1'b1;
         end else if (do_start) begin
            err <= 1'b0;
         end
      end
   end

endmodule
